// File: rtl/pattern_detector_param.sv
// Programmable serial bit-pattern detector.
// Shifts in one bit per enabled clock and flags when the last PAT_WIDTH bits equal a
// runtime-loaded pattern. Supports overlapping/non-overlapping detection and a saturating
// match counter.
module pattern_detector_param #(
    parameter int unsigned PAT_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [PAT_WIDTH-1:0] pattern_in,
    input  logic                 overlap_en,
    input  logic                 enable,
    input  logic                 clear_count,
    input  logic                 w,
    output logic                 match,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 saturated,
    output logic [1:0]           state
);

    localparam int unsigned          FillW    = $clog2(PAT_WIDTH + 1);
    localparam logic [FillW-1:0]     FillFull = FillW'(PAT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFill  = 2'b01,
        StTrack = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [PAT_WIDTH-1:0] pat_q, pat_d;
    logic [PAT_WIDTH-1:0] hist_q, hist_d, hist_n;
    logic [FillW-1:0]     fill_q, fill_d, fill_n;
    logic                 match_q, match_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;
    logic                 hit;

    // Next-state: load restarts detection, enabled edges shift history and test for a hit
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        count_d = count_q;
        hit     = 1'b0;
        hist_n  = {hist_q[PAT_WIDTH-2:0], w};
        fill_n  = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);

        if (load) begin
            pat_d   = pattern_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
        end else if (enable && (state_q != StIdle)) begin
            hit     = (fill_n == FillFull) && (hist_n == pat_q);
            hist_d  = hist_n;
            match_d = hit;
            // Non-overlapping mode demands PAT_WIDTH fresh bits after each hit
            fill_d  = (hit && !overlap_en) ? '0 : fill_n;
            state_d = (fill_d == FillFull) ? StTrack : StFill;
        end

        // Clear wins over a simultaneous hit; counter sticks at all ones
        if (clear_count) begin
            count_d = '0;
        end else if (hit && (count_q != CntMax)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
        sat_d = (count_d == CntMax);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign saturated   = sat_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: directed scenarios then random traffic, all checked
// against a sequence-based reference model. A second instance with a 2-bit counter
// exercises saturation.
module tb_pattern_detector_param;

    localparam int PW   = 4;
    localparam int CW   = 8;
    localparam int CW2  = 2;
    localparam int MAX1 = (1 << CW) - 1;
    localparam int MAX2 = (1 << CW2) - 1;

    logic          clock = 1'b0;
    logic          reset, load, overlap_en, enable, clear_count, w;
    logic [PW-1:0] pattern_in;
    logic          match, saturated, match2, saturated2;
    logic [CW-1:0] match_count;
    logic [CW2-1:0] match_count2;
    logic [1:0]    state, state2;

    pattern_detector_param #(.PAT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .enable(enable), .clear_count(clear_count), .w(w),
        .match(match), .match_count(match_count), .saturated(saturated), .state(state)
    );

    pattern_detector_param #(.PAT_WIDTH(PW), .CNT_WIDTH(CW2)) dut_s (
        .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .enable(enable), .clear_count(clear_count), .w(w),
        .match(match2), .match_count(match_count2), .saturated(saturated2), .state(state2)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits seen since the last load, fresh-bit count since last restart
    bit            m_armed;
    logic [PW-1:0] m_pat;
    bit            m_seq[$];
    int            m_fresh;
    int            m_cnt, m_cnt2;
    bit            m_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tail_matches();
        int n = m_seq.size();
        for (int i = 0; i < PW; i++)
            if (m_seq[n - PW + i] != m_pat[PW-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit rst, input bit ld, input logic [PW-1:0] pat, input bit ov,
                        input bit en, input bit clr, input bit b);
        bit hit;
        reset = rst; load = ld; pattern_in = pat; overlap_en = ov;
        enable = en; clear_count = clr; w = b;
        @(posedge clock);
        hit = 1'b0;
        if (rst) begin
            m_armed = 0; m_seq.delete(); m_fresh = 0; m_cnt = 0; m_cnt2 = 0; m_match = 0;
        end else begin
            if (ld) begin
                m_armed = 1; m_pat = pat; m_seq.delete(); m_fresh = 0;
            end else if (en && m_armed) begin
                m_seq.push_back(b);
                m_fresh++;
                hit = (m_fresh >= PW) && tail_matches();
                if (hit && !ov) m_fresh = 0;
            end
            m_match = hit;
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt  < MAX1) m_cnt++;
                if (m_cnt2 < MAX2) m_cnt2++;
            end
        end
        #1;
        chk("match", match, m_match);
        chk("count", match_count, m_cnt);
        chk("saturated", saturated, m_cnt == MAX1);
        chk("state", state, !m_armed ? 0 : ((m_fresh >= PW) ? 2 : 1));
        chk("count_w2", match_count2, m_cnt2);
        chk("saturated_w2", saturated2, m_cnt2 == MAX2);
        chk("match_w2", match2, m_match);
    endtask

    task automatic do_reset();
        step(1, 0, PW'($urandom), 0, 0, 0, 0);
    endtask

    task automatic do_load(input logic [PW-1:0] pat, input bit ov);
        step(0, 1, pat, ov, 1, 0, 1);
    endtask

    task automatic send(input bit b, input bit ov);
        step(0, 0, PW'($urandom), ov, 1, 0, b);
    endtask

    initial begin
        logic [6:0] seq7;

        // Reset state
        do_reset();
        chk("reset_state", state, 2'b00);
        chk("reset_count", match_count, 0);

        // w before any load is ignored
        for (int i = 0; i < 5; i++) send(1, 1);
        chk("idle_state", state, 2'b00);

        // 1101 overlapping: 1,1,0,1,1,0,1
        seq7 = 7'b1101101;
        do_load(4'b1101, 1);
        for (int i = 6; i >= 0; i--) send(seq7[i], 1);
        chk("t1_count", match_count, 2);

        // Same stream non-overlapping
        do_reset();
        do_load(4'b1101, 0);
        for (int i = 6; i >= 0; i--) send(seq7[i], 0);
        chk("t2_count", match_count, 1);
        chk("t2_state", state, 2'b01);

        // 1111 overlapping, six ones
        do_reset();
        do_load(4'b1111, 1);
        for (int i = 0; i < 6; i++) send(1, 1);
        chk("t3a_count", match_count, 3);

        // 1111 non-overlapping, eight ones
        do_reset();
        do_load(4'b1111, 0);
        for (int i = 0; i < 8; i++) send(1, 0);
        chk("t3b_count", match_count, 2);

        // Saturation on the narrow counter, then clear alongside a hit
        do_reset();
        do_load(4'b1111, 1);
        for (int i = 0; i < 8; i++) send(1, 1);
        chk("t4_count_w2", match_count2, 3);
        chk("t4_sat_w2", saturated2, 1);
        step(0, 0, 4'b0000, 1, 1, 1, 1);
        chk("t4_clear_match", match, 1);
        chk("t4_clear_w2", match_count2, 0);

        // Disabled edges between bits, with w toggling
        do_reset();
        do_load(4'b1101, 1);
        for (int i = 3; i >= 0; i--) begin
            send(seq7[i], 1);
            step(0, 0, 4'b0000, 1, 0, 0, 1'(i));
            step(0, 0, 4'b0000, 1, 0, 0, ~1'(i));
        end
        chk("t5_count", match_count, 1);

        // Reset mid-stream, then load mid-stream
        do_load(4'b1101, 1);
        send(1, 1); send(1, 1); send(0, 1);
        do_reset();
        chk("t6_state", state, 2'b00);
        do_load(4'b1101, 1);
        send(1, 1); send(1, 1); send(0, 1);
        do_load(4'b1101, 1);
        send(1, 1); send(1, 1); send(0, 1);
        chk("t6_nomatch", match_count, 0);
        send(1, 1);
        chk("t6_match", match, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(299) == 0, $urandom_range(24) == 0, PW'($urandom),
                 1'($urandom), $urandom_range(3) != 0, $urandom_range(39) == 0,
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
